// File: rtl/d_ff_sync.sv
// Positive-edge D register, synchronous active-high reset; one-edge latency, no stall (updates every edge).
// Define D_FF_SYNC_XCHECK_EN to add simulation-only X/Z checks on reset and d, and a time-0 value on q.
module d_ff_sync #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  output logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             reset,
  input  logic             clk
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = reset ? RESET_VALUE : d;
  end

`ifdef D_FF_SYNC_XCHECK_EN
  // A process that writes q_q is needed for the power-up value, so a plain always is used here.
  initial q_q = RESET_VALUE;

  always @(posedge clk) begin
    q_q <= q_d;
  end

  always @(posedge clk) begin
    if ($isunknown(reset))
      $error("%m: reset is X/Z at time %0t", $time);
    else if (!reset && $isunknown(d))
      $error("%m: d is X/Z while out of reset at time %0t", $time);
  end
`else
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end
`endif

  assign q = q_q;

endmodule

// File: tb/tb_d_ff_sync.sv
// Directed bench for d_ff_sync: 1-bit cell, 9-cell XNOR LFSR chain, and an 8-bit cell with non-zero reset value.
module tb_d_ff_sync;

  logic       clk;
  logic       s_q, s_d, s_reset;
  logic [8:0] c_q, c_d;
  logic       c_reset;
  logic [7:0] w_q, w_d;
  logic       w_reset;

  int total = 0;
  int bad   = 0;

  d_ff_sync u_single (
    .q     (s_q),
    .d     (s_d),
    .reset (s_reset),
    .clk   (clk)
  );

  assign c_d = {c_q[7:0], ~(c_q[4] ^ c_q[8])};

  for (genvar i = 0; i < 9; i++) begin : g_chain
    d_ff_sync u_cell (
      .q     (c_q[i]),
      .d     (c_d[i]),
      .reset (c_reset),
      .clk   (clk)
    );
  end

  d_ff_sync #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_wide (
    .q     (w_q),
    .d     (w_d),
    .reset (w_reset),
    .clk   (clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    s_d = 1'b0; s_reset = 1'b0;
    c_reset = 1'b0;
    w_d = 8'h00; w_reset = 1'b0;

    // Reset loads zero and holds while d toggles
    s_reset = 1'b1; s_d = 1'b1;
    step();
    check("reset_load", {15'd0, s_q}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      s_d = ~s_d;
      step();
      check("reset_hold", {15'd0, s_q}, 16'h0000);
    end

    // Capture with one-edge latency, no change between edges
    s_reset = 1'b0; s_d = 1'b1;
    step();
    check("cap_1", {15'd0, s_q}, 16'h0001);
    s_d = 1'b0;
    #3;
    check("cap_no_comb", {15'd0, s_q}, 16'h0001);
    step();
    check("cap_0", {15'd0, s_q}, 16'h0000);
    s_d = 1'b1;
    step();
    check("cap_1b", {15'd0, s_q}, 16'h0001);

    // Reset pulse between edges is ignored
    s_reset = 1'b1;
    #3;
    check("sync_mid_pulse", {15'd0, s_q}, 16'h0001);
    s_reset = 1'b0;
    step();
    check("sync_pulse_ignored", {15'd0, s_q}, 16'h0001);

    // Reset raised just before an edge takes effect on that edge
    #7;
    s_reset = 1'b1; s_d = 1'b1;
    step();
    check("sync_late_reset", {15'd0, s_q}, 16'h0000);
    s_reset = 1'b0;

    // LFSR chain sequence from reset
    c_reset = 1'b1;
    step();
    check("lfsr_0", {7'd0, c_q}, 16'h0000);
    c_reset = 1'b0;
    step(); check("lfsr_1", {7'd0, c_q}, 16'h0001);
    step(); check("lfsr_2", {7'd0, c_q}, 16'h0003);
    step(); check("lfsr_3", {7'd0, c_q}, 16'h0007);
    step(); check("lfsr_4", {7'd0, c_q}, 16'h000F);
    step(); check("lfsr_5", {7'd0, c_q}, 16'h001F);
    step(); check("lfsr_6", {7'd0, c_q}, 16'h003E);

    // Reset mid-sequence clears all cells together, then restarts
    c_reset = 1'b1;
    step();
    check("lfsr_midreset", {7'd0, c_q}, 16'h0000);
    c_reset = 1'b0;
    step(); check("lfsr_restart_1", {7'd0, c_q}, 16'h0001);
    step(); check("lfsr_restart_2", {7'd0, c_q}, 16'h0003);

    // Wide cell with non-zero reset value
    w_reset = 1'b1; w_d = 8'h3C;
    step();
    check("wide_reset", {8'd0, w_q}, 16'h00A5);
    w_reset = 1'b0;
    step();
    check("wide_cap", {8'd0, w_q}, 16'h003C);
    w_d = 8'hC3;
    #3;
    check("wide_hold", {8'd0, w_q}, 16'h003C);
    step();
    check("wide_cap2", {8'd0, w_q}, 16'h00C3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
